rs232_avm_arbiter: RTL and testbench
====================================

// Module: rs232_avm_arbiter
// PURPOSE
//  Shares the single Avalon-MM master port of the RS232 UART between two byte-level requesters:
//  an RX requester (program/data loader) and a TX requester (ecall result sender).
//  For each granted request it polls STATUS until the matching OK bit is set, then performs one
//  RX read or TX write and returns a done pulse. Sits between the cpu-side byte clients and the UART.
// PARAMETERS
//  RX_BASE      0   byte address of RX data register
//  TX_BASE      4   byte address of TX data register
//  STATUS_BASE  8   byte address of status register
//  RX_OK_BIT    7   status bit: RX byte available
//  TX_OK_BIT    6   status bit: TX ready
//  POLL_LIMIT   16  failed status polls before the grant is released (0 = never release)
// PORTS
//  avm_clk          in   1   clock
//  avm_rst          in   1   reset, synchronous, active-high
//  avm_address      out  5   Avalon address
//  avm_read         out  1   Avalon read
//  avm_readdata     in   32  Avalon read data, valid in any cycle with avm_read=1 and avm_waitrequest=0
//  avm_write        out  1   Avalon write
//  avm_writedata    out  32  Avalon write data, {24'b0, byte}
//  avm_waitrequest  in   1   Avalon stall; command held unchanged while high
//  rx_req           in   1   RX requester wants one byte; held until rx_valid
//  rx_valid         out  1   1-cycle pulse; rx_data valid
//  rx_data          out  8   received byte, held until next RX completion
//  tx_req           in   1   TX requester sends one byte; held until tx_done
//  tx_data          in   8   byte to send, sampled in the grant cycle
//  tx_done          out  1   1-cycle pulse; byte written to TX
//  busy             out  1   high whenever state != S_IDLE
// BEHAVIOUR
//  Reset: state=S_IDLE, avm_read=0, avm_write=0, avm_address=STATUS_BASE, avm_writedata=0,
//    rx_valid=0, rx_data=0, tx_done=0, busy=0, poll_cnt=0, last_gnt=TX (so RX wins the first tie).
//    A reset mid-transfer abandons the Avalon access and drops read/write on the next edge.
//  All outputs are registered. FSM has four states:
//  S_IDLE: if rx_req|tx_req, grant by round-robin (both requesting -> the one != last_gnt;
//    otherwise the single requester). Latch tx_data when TX is granted. Next: avm_read=1,
//    avm_address=STATUS_BASE, poll_cnt=0, go to S_POLL.
//  S_POLL: hold the command while avm_waitrequest=1. When it is 0:
//    if avm_readdata[OK bit of the grant]=1: issue the transfer and go to S_XFER.
//      RX: avm_read=1, address=RX_BASE. TX: avm_read=0, avm_write=1, address=TX_BASE,
//      writedata={24'b0,byte}.
//    else if POLL_LIMIT!=0 and poll_cnt==POLL_LIMIT-1: set avm_read=0, last_gnt=grant,
//      go to S_IDLE (release). The requester keeps req high and is re-arbitrated.
//    else: poll_cnt+1 and keep avm_read=1 at STATUS_BASE (back-to-back polls).
//  S_XFER: hold while avm_waitrequest=1. On 0: avm_read=0, avm_write=0, address=STATUS_BASE;
//    RX: rx_data<=avm_readdata[7:0]. Set last_gnt=grant and go to S_DONE.
//  S_DONE: rx_valid or tx_done is high for exactly this cycle. Next state is S_IDLE.
//  Latency with zero wait states and the OK bit already set: req first sampled in cycle 0,
//    STATUS read in cycle 1, transfer in cycle 2, done pulse in cycle 3.
//  Requester rule: deassert req on the edge where done is seen high. If req is still high in the
//    S_IDLE cycle after done, it is a new request.
//  avm_read and avm_write are never high together. The arbiter never changes the grant
//    between S_POLL and S_DONE. A req that drops before done is ignored until S_IDLE.
//  poll_cnt is sized as clog2(POLL_LIMIT+1) bits and never wraps; it is cleared on every grant.
// TESTING
//  1 Zero wait states, STATUS=0x40, tx_req with tx_data=0xA5 -> write to addr 4 with data
//    0x000000A5; tx_done 3 cycles after req; busy high for 3 cycles.
//  2 rx_req, STATUS=0x80, RX readdata=0x1234_5637, waitrequest high for 2 cycles on each access
//    -> rx_data=0x37, rx_valid a single cycle; command stable across the stalls.
//  3 rx_req and tx_req in the same cycle after reset, both OK bits set -> RX served first, then TX;
//    with both held for four more requests the grants alternate RX,TX,RX,TX.
//  4 TX granted, TX_OK held 0, POLL_LIMIT=16, rx_req high with RX_OK=1 -> exactly 16 STATUS reads,
//    release, RX completes, then TX is regranted and completes once TX_OK=1.
//  5 avm_rst pulsed during S_XFER with waitrequest high -> next cycle read=write=0,
//    address=STATUS_BASE, no done pulse, busy=0.
//  6 Assertions over random stall/status traffic: never (avm_read & avm_write); done pulses one
//    cycle wide; exactly one done per accepted request.

Source files
------------

// File: rtl/rs232_avm_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rs232_avm_arbiter
// Brief   : Round-robin sharing of the UART Avalon-MM master between an RX
//           byte requester and a TX byte requester, with STATUS polling.
// Rev     : 1.0  initial release
// ============================================================================
module rs232_avm_arbiter #(
    parameter int RX_BASE     = 0,
    parameter int TX_BASE     = 4,
    parameter int STATUS_BASE = 8,
    parameter int RX_OK_BIT   = 7,
    parameter int TX_OK_BIT   = 6,
    parameter int POLL_LIMIT  = 16
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic        rx_req,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        tx_req,
    input  logic [7:0]  tx_data,
    output logic        tx_done,
    output logic        busy
);

    localparam int             PW        = (POLL_LIMIT > 0) ? $clog2(POLL_LIMIT + 1) : 1;
    localparam logic [PW-1:0]  POLL_LAST = (POLL_LIMIT > 0) ? PW'(POLL_LIMIT - 1) : '0;
    localparam logic [4:0]     ADDR_RX   = 5'(RX_BASE);
    localparam logic [4:0]     ADDR_TX   = 5'(TX_BASE);
    localparam logic [4:0]     ADDR_STAT = 5'(STATUS_BASE);
    localparam logic           GNT_RX    = 1'b0;
    localparam logic           GNT_TX    = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POLL = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic           grant, grant_nxt;
    logic           last_gnt, last_gnt_nxt;
    logic [7:0]     tx_byte, tx_byte_nxt;
    logic [PW-1:0]  poll_cnt, poll_cnt_nxt;
    logic [4:0]     address_nxt;
    logic           read_nxt, write_nxt;
    logic [31:0]    writedata_nxt;
    logic [7:0]     rx_data_nxt;
    logic           rx_valid_nxt, tx_done_nxt, busy_nxt;
    logic           status_ok;
    logic           pick;

    // Upper read-data bits are never inspected; fold them into a sink.
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata;

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        last_gnt_nxt  = last_gnt;
        tx_byte_nxt   = tx_byte;
        poll_cnt_nxt  = poll_cnt;
        address_nxt   = avm_address;
        read_nxt      = avm_read;
        write_nxt     = avm_write;
        writedata_nxt = avm_writedata;
        rx_data_nxt   = rx_data;
        status_ok     = (grant == GNT_TX) ? avm_readdata[TX_OK_BIT] : avm_readdata[RX_OK_BIT];
        pick          = (rx_req && tx_req) ? ~last_gnt : tx_req;

        case (state)
            S_IDLE: begin
                if (rx_req || tx_req) begin
                    grant_nxt    = pick;
                    if (pick == GNT_TX) begin
                        tx_byte_nxt = tx_data;
                    end
                    read_nxt     = 1'b1;
                    address_nxt  = ADDR_STAT;
                    poll_cnt_nxt = '0;
                    state_nxt    = S_POLL;
                end
            end
            S_POLL: begin
                if (!avm_waitrequest) begin
                    if (status_ok) begin
                        if (grant == GNT_TX) begin
                            read_nxt      = 1'b0;
                            write_nxt     = 1'b1;
                            address_nxt   = ADDR_TX;
                            writedata_nxt = {24'b0, tx_byte};
                        end else begin
                            read_nxt    = 1'b1;
                            address_nxt = ADDR_RX;
                        end
                        state_nxt = S_XFER;
                    end else if ((POLL_LIMIT != 0) && (poll_cnt == POLL_LAST)) begin
                        // Give the other requester a turn instead of spinning forever.
                        read_nxt     = 1'b0;
                        last_gnt_nxt = grant;
                        state_nxt    = S_IDLE;
                    end else if (poll_cnt != {PW{1'b1}}) begin
                        poll_cnt_nxt = poll_cnt + PW'(1);
                    end
                end
            end
            S_XFER: begin
                if (!avm_waitrequest) begin
                    read_nxt    = 1'b0;
                    write_nxt   = 1'b0;
                    address_nxt = ADDR_STAT;
                    if (grant == GNT_RX) begin
                        rx_data_nxt = avm_readdata[7:0];
                    end
                    last_gnt_nxt = grant;
                    state_nxt    = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        rx_valid_nxt = (state_nxt == S_DONE) && (grant_nxt == GNT_RX);
        tx_done_nxt  = (state_nxt == S_DONE) && (grant_nxt == GNT_TX);
        busy_nxt     = (state_nxt != S_IDLE);
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state         <= S_IDLE;
            grant         <= GNT_RX;
            last_gnt      <= GNT_TX;
            tx_byte       <= '0;
            poll_cnt      <= '0;
            avm_address   <= ADDR_STAT;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            tx_done       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            grant         <= grant_nxt;
            last_gnt      <= last_gnt_nxt;
            tx_byte       <= tx_byte_nxt;
            poll_cnt      <= poll_cnt_nxt;
            avm_address   <= address_nxt;
            avm_read      <= read_nxt;
            avm_write     <= write_nxt;
            avm_writedata <= writedata_nxt;
            rx_data       <= rx_data_nxt;
            rx_valid      <= rx_valid_nxt;
            tx_done       <= tx_done_nxt;
            busy          <= busy_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs232_avm_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rs232_avm_arbiter
// Brief   : Directed bench for rs232_avm_arbiter with a small Avalon slave.
// Rev     : 1.0  initial release
// ============================================================================
module tb_rs232_avm_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_readdata, avm_writedata;
    logic        avm_waitrequest;
    logic        rx_req = 1'b0, tx_req = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        rx_valid, tx_done, busy;
    logic [7:0]  rx_data;

    int checks   = 0;
    int failures = 0;

    // slave configuration (written by the stimulus process only)
    logic [31:0] status_val = 32'h0;
    logic [31:0] rx_word    = 32'h0;
    int          ws_cfg     = 0;
    logic        rand_stall = 1'b0;

    // slave state and logs
    int          ws_cnt = 0;
    logic        stall_rnd = 1'b0;
    int          status_reads = 0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    int          rx_dones = 0, tx_dones = 0;

    always #5 clk = ~clk;

    rs232_avm_arbiter dut (
        .avm_clk        (clk),
        .avm_rst        (rst),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .rx_req         (rx_req),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .tx_req         (tx_req),
        .tx_data        (tx_data),
        .tx_done        (tx_done),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- Avalon slave model ----------------
    wire cmd = avm_read | avm_write;
    assign avm_waitrequest = cmd && (rand_stall ? stall_rnd : (ws_cnt < ws_cfg));
    always_comb begin
        if (avm_address == 5'd8)      avm_readdata = status_val;
        else if (avm_address == 5'd0) avm_readdata = rx_word;
        else                          avm_readdata = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (cmd && avm_waitrequest) ws_cnt <= ws_cnt + 1;
        else                        ws_cnt <= 0;
        if (!rst && avm_read && !avm_waitrequest && avm_address == 5'd8)
            status_reads <= status_reads + 1;
        if (!rst && avm_write && !avm_waitrequest) begin
            wr_addr <= avm_address;
            wr_data <= avm_writedata;
        end
        stall_rnd <= ($urandom_range(0, 1) != 0);
    end

    // ---------------- protocol monitor ----------------
    logic        rst_seen = 1'b1;
    logic        prev_stall = 1'b0;
    logic [38:0] prev_cmd = '0;
    logic        prev_rxv = 1'b0, prev_txd = 1'b0;
    always @(posedge clk) rst_seen <= rst;

    always @(negedge clk) begin
        check("rd_wr_excl", 64'(avm_read & avm_write), 64'd0);
        if (!rst_seen && prev_stall)
            check("cmd_stable", 64'({avm_read, avm_write, avm_address, avm_writedata}), 64'(prev_cmd));
        if (prev_rxv) check("rx_valid_width", 64'(rx_valid), 64'd0);
        if (prev_txd) check("tx_done_width", 64'(tx_done), 64'd0);
        if (rx_valid && tx_done) check("one_done", 64'd1, 64'd0);
        if (rx_valid) rx_dones <= rx_dones + 1;
        if (tx_done)  tx_dones <= tx_dones + 1;
        prev_stall <= cmd && avm_waitrequest;
        prev_cmd   <= {avm_read, avm_write, avm_address, avm_writedata};
        prev_rxv   <= rx_valid;
        prev_txd   <= tx_done;
    end

    // ---------------- stimulus helpers ----------------
    // mode: 0 = wait rx_valid, 1 = wait tx_done, 2 = either
    task automatic wait_done(input int mode, input int limit, input bit rnd_status,
                             output int cycles, output bit got_tx);
        bit seen = 1'b0;
        cycles = 0;
        got_tx = 1'b0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (rnd_status) status_val = $urandom;
            case (mode)
                0:       seen = rx_valid;
                1:       seen = tx_done;
                default: seen = rx_valid | tx_done;
            endcase
            got_tx = tx_done;
        end
        check("done_in_time", 64'(seen), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int  lat, s0, d0;
    bit  gtx;

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_read",  64'(avm_read), 64'd0);
        check("rst_write", 64'(avm_write), 64'd0);
        check("rst_addr",  64'(avm_address), 64'd8);
        check("rst_wdata", 64'(avm_writedata), 64'd0);
        check("rst_rxv",   64'(rx_valid), 64'd0);
        check("rst_rxd",   64'(rx_data), 64'd0);
        check("rst_txd",   64'(tx_done), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        rst = 1'b0;

        // ---------------- 1: zero-wait TX ----------------
        status_val = 32'h40;
        ws_cfg     = 0;
        @(negedge clk);
        tx_req  = 1'b1;
        tx_data = 8'hA5;
        @(negedge clk);
        check("t1_c1_read", 64'({avm_read, avm_write, avm_address}), 64'({1'b1, 1'b0, 5'd8}));
        check("t1_c1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("t1_c2_write", 64'({avm_read, avm_write, avm_address}), 64'({1'b0, 1'b1, 5'd4}));
        check("t1_c2_wdata", 64'(avm_writedata), 64'h0000_00A5);
        check("t1_c2_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("t1_c3_done", 64'(tx_done), 64'd1);
        check("t1_c3_busy", 64'(busy), 64'd1);
        check("t1_c3_idle_bus", 64'({avm_read, avm_write, avm_address}), 64'({1'b0, 1'b0, 5'd8}));
        tx_req = 1'b0;
        @(negedge clk);
        check("t1_c4_done", 64'(tx_done), 64'd0);
        check("t1_c4_busy", 64'(busy), 64'd0);
        check("t1_wr_addr", 64'(wr_addr), 64'd4);

        // ---------------- 2: RX with 2 wait states ----------------
        status_val = 32'h80;
        rx_word    = 32'h1234_5637;
        ws_cfg     = 2;
        s0         = status_reads;
        rx_req     = 1'b1;
        wait_done(0, 30, 1'b0, lat, gtx);
        rx_req = 1'b0;
        check("t2_latency", 64'(lat), 64'd7);
        check("t2_rx_data", 64'(rx_data), 64'h37);
        check("t2_status_reads", 64'(status_reads - s0), 64'd1);
        @(negedge clk);
        check("t2_rxv_low", 64'(rx_valid), 64'd0);
        check("t2_rx_data_hold", 64'(rx_data), 64'h37);

        // ---------------- 3: round robin ----------------
        do_reset();
        ws_cfg     = 0;
        status_val = 32'hC0;
        tx_data    = 8'h5A;
        rx_req     = 1'b1;
        tx_req     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_done(2, 20, 1'b0, lat, gtx);
            check($sformatf("t3_order%0d", i), 64'(gtx), 64'(i % 2));
        end
        rx_req = 1'b0;
        tx_req = 1'b0;
        @(negedge clk);

        // ---------------- 4: poll limit release ----------------
        status_val = 32'h80;
        tx_data    = 8'h3C;
        s0         = status_reads;
        d0         = tx_dones;
        tx_req     = 1'b1;
        @(negedge clk);
        rx_req = 1'b1;
        wait_done(0, 60, 1'b0, lat, gtx);
        rx_req = 1'b0;
        check("t4_rx_latency", 64'(lat), 64'd19);
        check("t4_status_reads", 64'(status_reads - s0), 64'd17);
        check("t4_no_tx_yet", 64'(tx_dones - d0), 64'd0);
        status_val = 32'h40;
        wait_done(1, 20, 1'b0, lat, gtx);
        tx_req = 1'b0;
        check("t4_tx_latency", 64'(lat), 64'd4);
        check("t4_wr_addr", 64'(wr_addr), 64'd4);
        check("t4_wr_data", 64'(wr_data), 64'h3C);

        // ---------------- 5: reset during stalled XFER ----------------
        @(negedge clk);
        ws_cfg     = 5;
        status_val = 32'h40;
        tx_req     = 1'b1;
        lat        = 0;
        while (!avm_write && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("t5_in_xfer", 64'({avm_write, avm_waitrequest}), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        check("t5_bus", 64'({avm_read, avm_write, avm_address}), 64'({1'b0, 1'b0, 5'd8}));
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_no_done", 64'(tx_done), 64'd0);
        rst    = 1'b0;
        tx_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t5_quiet", 64'({tx_done, busy}), 64'd0);
        end

        // ---------------- 6: random stall/status traffic ----------------
        ws_cfg     = 0;
        rand_stall = 1'b1;
        d0         = rx_dones + tx_dones;
        for (int i = 0; i < 20; i++) begin
            rx_word = $urandom;
            tx_data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) != 0) begin
                tx_req = 1'b1;
                wait_done(1, 800, 1'b1, lat, gtx);
                tx_req = 1'b0;
                check("t6_tx_data", 64'(wr_data), 64'({24'b0, tx_data}));
            end else begin
                rx_req = 1'b1;
                wait_done(0, 800, 1'b1, lat, gtx);
                rx_req = 1'b0;
                check("t6_rx_data", 64'(rx_data), 64'(rx_word[7:0]));
            end
        end
        repeat (3) @(negedge clk);
        check("t6_done_total", 64'(rx_dones + tx_dones - d0), 64'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
